// File: rtl/kpn_pkg.sv
// Constants and types shared by the KPN arithmetic process nodes.
package kpn_pkg;

  localparam int unsigned SUB_WRAP  = 0;
  localparam int unsigned SUB_SAT_U = 1;
  localparam int unsigned SUB_SAT_S = 2;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

endpackage

// File: rtl/kpn_channel_fifo.sv
// Token FIFO for one KPN input channel; power-of-two depth, no bypass path.
module kpn_channel_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push && (r_count != Full);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/kpn_subtractor_node.sv
// KPN process node: result = entry_1 - entry_2 with blocking-read firing and
// wrap / unsigned-saturate / signed-saturate arithmetic.
module kpn_subtractor_node
  import kpn_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SUB_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] entry_1,
  input  logic             entry_1_valid,
  output logic             entry_1_ready,
  input  logic [WIDTH-1:0] entry_2,
  input  logic             entry_2_valid,
  output logic             entry_2_ready,
  output logic [WIDTH-1:0] output_1,
  output logic             output_1_valid,
  input  logic             output_1_ready,
  output logic             output_1_underflow,
  output logic [31:0]      token_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  out_state_e       r_state;
  out_state_e       w_state_d;
  logic [WIDTH-1:0] r_result;
  logic             r_underflow;
  logic [31:0]      r_token_count;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [CntW-1:0]  w_count_1;
  logic [CntW-1:0]  w_count_2;
  logic             w_empty_1;
  logic             w_empty_2;
  logic             w_fire;
  logic             w_load;
  logic [WIDTH:0]   w_diff;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_underflow;

  kpn_channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (entry_1_valid),
    .i_push_data (entry_1),
    .i_pop       (w_fire),
    .o_pop_data  (w_a),
    .o_count     (w_count_1),
    .o_empty     (w_empty_1)
  );

  kpn_channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (entry_2_valid),
    .i_push_data (entry_2),
    .i_pop       (w_fire),
    .o_pop_data  (w_b),
    .o_count     (w_count_2),
    .o_empty     (w_empty_2)
  );

  // Ready depends only on registered FIFO occupancy, never on output_1_ready.
  assign entry_1_ready = (w_count_1 != Full);
  assign entry_2_ready = (w_count_2 != Full);

  assign w_fire = !w_empty_1 && !w_empty_2 && ((r_state == OUT_EMPTY) || output_1_ready);

  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_ovf  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);

  always_comb begin
    w_result    = w_diff[WIDTH-1:0];
    w_underflow = w_diff[WIDTH];
    if (SUB_MODE == SUB_SAT_U) begin
      if (w_diff[WIDTH]) begin
        w_result = '0;
      end
    end else if (SUB_MODE == SUB_SAT_S) begin
      w_underflow = w_ovf;
      if (w_ovf) begin
        // Overflow direction follows the minuend's sign.
        w_result = w_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    unique case (r_state)
      OUT_EMPTY: begin
        if (w_fire) begin
          w_state_d = OUT_FULL;
          w_load    = 1'b1;
        end
      end
      OUT_FULL: begin
        if (output_1_ready) begin
          if (w_fire) begin
            w_load = 1'b1;
          end else begin
            w_state_d = OUT_EMPTY;
          end
        end
      end
      default: w_state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= OUT_EMPTY;
      r_result      <= '0;
      r_underflow   <= 1'b0;
      r_token_count <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_result    <= w_result;
        r_underflow <= w_underflow;
      end
      if ((r_state == OUT_FULL) && output_1_ready) begin
        r_token_count <= r_token_count + 32'd1;
      end
    end
  end

  assign output_1           = r_result;
  assign output_1_valid     = (r_state == OUT_FULL);
  assign output_1_underflow = r_underflow;
  assign token_count        = r_token_count;

endmodule

// File: tb/tb_kpn_subtractor_node.sv
// Directed bench: three nodes (wrap, unsigned-sat, signed-sat) share one stimulus stream.
module tb_kpn_subtractor_node;

  localparam int NV = 11;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e0;
    logic        u0;
    logic [15:0] e1;
    logic        u1;
    logic [15:0] e2;
    logic        u2;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        v1;
  logic        v2;
  logic        out_ready;

  logic        r1 [3];
  logic        r2 [3];
  logic [15:0] o  [3];
  logic        ov [3];
  logic        uf [3];
  logic [31:0] tc [3];

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs [NV];

  kpn_subtractor_node #(.WIDTH(16), .DEPTH(4), .SUB_MODE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .entry_1(a), .entry_1_valid(v1), .entry_1_ready(r1[0]),
    .entry_2(b), .entry_2_valid(v2), .entry_2_ready(r2[0]),
    .output_1(o[0]), .output_1_valid(ov[0]), .output_1_ready(out_ready),
    .output_1_underflow(uf[0]), .token_count(tc[0])
  );

  kpn_subtractor_node #(.WIDTH(16), .DEPTH(4), .SUB_MODE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .entry_1(a), .entry_1_valid(v1), .entry_1_ready(r1[1]),
    .entry_2(b), .entry_2_valid(v2), .entry_2_ready(r2[1]),
    .output_1(o[1]), .output_1_valid(ov[1]), .output_1_ready(out_ready),
    .output_1_underflow(uf[1]), .token_count(tc[1])
  );

  kpn_subtractor_node #(.WIDTH(16), .DEPTH(4), .SUB_MODE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .entry_1(a), .entry_1_valid(v1), .entry_1_ready(r1[2]),
    .entry_2(b), .entry_2_valid(v2), .entry_2_ready(r2[2]),
    .output_1(o[2]), .output_1_valid(ov[2]), .output_1_ready(out_ready),
    .output_1_underflow(uf[2]), .token_count(tc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    logic rdy;

    //           a         b         wrap        usat        ssat
    vecs[0]  = '{16'd20,   16'd10,   16'd10,   0, 16'd10,   0, 16'd10,   0};
    vecs[1]  = '{16'd45,   16'd10,   16'd35,   0, 16'd35,   0, 16'd35,   0};
    vecs[2]  = '{16'd90,   16'd5,    16'd85,   0, 16'd85,   0, 16'd85,   0};
    vecs[3]  = '{16'd10,   16'd20,   16'hFFF6, 1, 16'h0000, 1, 16'hFFF6, 0};
    vecs[4]  = '{16'h8000, 16'h0001, 16'h7FFF, 0, 16'h7FFF, 0, 16'h8000, 1};
    vecs[5]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1, 16'h0000, 1, 16'h7FFF, 1};
    vecs[6]  = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 1, 16'hFFFF, 0};
    vecs[7]  = '{16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0};
    vecs[8]  = '{16'hFFFF, 16'h0001, 16'hFFFE, 0, 16'hFFFE, 0, 16'hFFFE, 0};
    vecs[9]  = '{16'h8000, 16'h8000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0};
    vecs[10] = '{16'h0000, 16'h8000, 16'h8000, 1, 16'h0000, 1, 16'h7FFF, 1};

    reset_n   = 1'b0;
    a         = '0;
    b         = '0;
    v1        = 1'b0;
    v2        = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready1", r1[0], 1);
    chk("rst_ready2", r2[0], 1);
    chk("rst_valid", ov[0], 0);
    chk("rst_out", o[0], 0);
    chk("rst_uf", uf[0], 0);
    chk("rst_tc", tc[0], 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: each pair in isolation, latency and result checked in all modes.
    for (int i = 0; i < NV; i++) begin
      a  = vecs[i].a;
      b  = vecs[i].b;
      v1 = 1'b1;
      v2 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      v2 = 1'b0;
      chk("lat_not_yet", ov[0], 0);
      @(negedge clk);
      chk("lat_valid", ov[0], 1);
      chk("out_wrap", o[0], vecs[i].e0);
      chk("uf_wrap", uf[0], vecs[i].u0);
      chk("out_usat", o[1], vecs[i].e1);
      chk("uf_usat", uf[1], vecs[i].u1);
      chk("out_ssat", o[2], vecs[i].e2);
      chk("uf_ssat", uf[2], vecs[i].u2);
      @(negedge clk);
      if (i == 2) chk("tc_basic", tc[0], 3);
    end
    chk("tc_table", tc[0], NV);
    chk("tc_table_ssat", tc[2], NV);

    // Backpressure: 4 buffered + 1 held, then in-order drain at one per cycle.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("bp_tc_reset", tc[0], 0);
    out_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      a   = 16'(10 * i);
      b   = 16'(i);
      v1  = 1'b1;
      v2  = 1'b1;
      rdy = r1[0] && r2[0];
      @(negedge clk);
      if (rdy) acc++;
    end
    v1 = 1'b0;
    v2 = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_ready1_low", r1[0], 0);
    chk("bp_ready2_low", r2[0], 0);
    chk("bp_held_valid", ov[0], 1);
    chk("bp_held_out", o[0], 9);
    repeat (2) @(negedge clk);
    chk("bp_held_stable", o[0], 9);
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      chk("bp_drain_valid", ov[0], 1);
      chk("bp_drain_out", o[0], 32'(9 * j));
      @(negedge clk);
    end
    chk("bp_drained", ov[0], 0);
    chk("bp_tc", tc[0], 5);
    chk("bp_ready_back", r1[0], 1);

    // Asymmetric arrival: no result until the subtrahend shows up.
    for (int k = 1; k <= 3; k++) begin
      a  = 16'(100 * k);
      v1 = 1'b1;
      @(negedge clk);
    end
    v1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("asym_no_valid", ov[0], 0);
    b  = 16'd1;
    v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    chk("asym_lat1", ov[0], 0);
    @(negedge clk);
    chk("asym_valid", ov[0], 1);
    chk("asym_out", o[0], 99);
    @(negedge clk);
    chk("asym_single", ov[0], 0);
    chk("asym_tc", tc[0], 6);

    // Reset with tokens buffered on both sides and a result held.
    out_ready = 1'b0;
    a  = 16'd7;
    b  = 16'd2;
    v1 = 1'b1;
    v2 = 1'b1;
    @(negedge clk);
    a = 16'd8;
    b = 16'd3;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
    chk("mid_held_valid", ov[0], 1);
    chk("mid_pairing", o[0], 198);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_tc", tc[0], 0);
    chk("mid_rst_out", o[0], 0);
    out_ready = 1'b1;
    a  = 16'd50;
    b  = 16'd8;
    v1 = 1'b1;
    v2 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
    chk("post_rst_lat", ov[0], 0);
    @(negedge clk);
    chk("post_rst_valid", ov[0], 1);
    chk("post_rst_out", o[0], 42);
    chk("post_rst_uf", uf[0], 0);
    @(negedge clk);
    chk("post_rst_tc", tc[0], 1);
    chk("post_rst_empty", ov[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
